punto5_sweep_checker: RTL and testbench

- Sequential stimulus and checker stage placed directly upstream of the 3-input logic block, which exposes four equivalent outputs: Fsimp, Fpos, Fsop and Fcase.
- Drives A/B/C through all 8 minterms, waits a settle time, then samples the four outputs.
- Records the truth table and flags any minterm where the four realisations disagree.
- Replaces manual stepping on the lab board; its results feed the display stage.

---
 rtl/punto5_chk_pkg.sv | 15 +
 rtl/punto5_sweep_checker_if.sv | 30 +++
 rtl/punto5_sweep_checker_settle_timer.sv | 27 ++
 rtl/punto5_sweep_checker.sv | 131 +++++++++++++
 tb/tb_punto5_sweep_checker.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/punto5_chk_pkg.sv
// Shared types and widths for the punto5 truth-table sweep checker.
package punto5_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_MINTERMS = 8;
  localparam int unsigned MINTERM_W    = 3;
  localparam int unsigned ERR_W        = 4;

endpackage

// File: rtl/punto5_sweep_checker_if.sv
// Bus between the sweep checker, the 3-input logic block under test and the display stage.
interface punto5_sweep_checker_if;
  import punto5_chk_pkg::*;

  logic                    start;
  logic                    A;
  logic                    B;
  logic                    C;
  logic                    Fsimp;
  logic                    Fpos;
  logic                    Fsop;
  logic                    Fcase;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [NUM_MINTERMS-1:0] truth_table;
  logic [NUM_MINTERMS-1:0] mismatch_mask;
  logic [ERR_W-1:0]        err_count;

  modport master (
    input  start, Fsimp, Fpos, Fsop, Fcase,
    output A, B, C, busy, done, pass, truth_table, mismatch_mask, err_count
  );

  modport slave (
    output start, Fsimp, Fpos, Fsop, Fcase,
    input  A, B, C, busy, done, pass, truth_table, mismatch_mask, err_count
  );

endinterface

// File: rtl/punto5_sweep_checker_settle_timer.sv
// Loadable down-counter timing how long A/B/C are held before the outputs are sampled.
module settle_timer #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOAD_VAL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired_c = (cnt == '0);

endmodule

// File: rtl/punto5_sweep_checker.sv
// Steps A/B/C through all minterms, samples the four realisations and records truth table / mismatches.
// Optional build macro: PUNTO5_STOP_ON_FAIL_EN ends the sweep at the first mismatching minterm.
module punto5_sweep_checker
  import punto5_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  punto5_sweep_checker_if.master bus
);

  state_t                  state_q;
  state_t                  state_d;
  logic [MINTERM_W-1:0]    m_q;
  logic [MINTERM_W-1:0]    abc_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [NUM_MINTERMS-1:0] tt_q;
  logic [NUM_MINTERMS-1:0] mask_q;
  logic [ERR_W-1:0]        err_q;

  logic start_acc_c;
  logic mis_c;
  logic last_c;
  logic timer_load_c;
  logic timer_en_c;
  logic expired_c;

  assign start_acc_c = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign mis_c = (bus.Fpos ^ bus.Fsimp) | (bus.Fsop ^ bus.Fsimp) | (bus.Fcase ^ bus.Fsimp);

`ifdef PUNTO5_STOP_ON_FAIL_EN
  assign last_c = (m_q == MINTERM_W'(NUM_MINTERMS - 1)) || mis_c;
`else
  assign last_c = (m_q == MINTERM_W'(NUM_MINTERMS - 1));
`endif

  settle_timer #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (SETTLE_CYC - 1)
  ) u_settle_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load_c),
    .en        (timer_en_c),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and timer control.
  always_comb begin
    state_d      = state_q;
    timer_load_c = 1'b0;
    timer_en_c   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d      = SETTLE;
          timer_load_c = 1'b1;
        end
      end
      SETTLE: begin
        timer_en_c = 1'b1;
        if (expired_c) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (last_c) begin
          state_d = DONE;
        end else begin
          state_d      = SETTLE;
          timer_load_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep datapath; every bus output comes straight from these registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q    <= '0;
      abc_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      tt_q   <= '0;
      mask_q <= '0;
      err_q  <= '0;
    end else if (start_acc_c) begin
      m_q    <= '0;
      abc_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      tt_q   <= '0;
      mask_q <= '0;
      err_q  <= '0;
    end else if (state_q == SAMPLE) begin
      tt_q[m_q]   <= bus.Fsimp;
      mask_q[m_q] <= mis_c;
      if (mis_c) err_q <= err_q + ERR_W'(1);
      if (last_c) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        // mask_q only holds bits of minterms already visited this sweep.
        pass_q <= !mis_c && (mask_q == '0);
      end else begin
        m_q   <= m_q + MINTERM_W'(1);
        abc_q <= m_q + MINTERM_W'(1);
      end
    end
  end

  assign bus.A             = abc_q[2];
  assign bus.B             = abc_q[1];
  assign bus.C             = abc_q[0];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.truth_table   = tt_q;
  assign bus.mismatch_mask = mask_q;
  assign bus.err_count     = err_q;

endmodule

// File: tb/tb_punto5_sweep_checker.sv
// Self-checking bench: majority-function logic block with injectable faults, scoreboarded sweeps.
module tb_punto5_sweep_checker;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned PER_M  = SETTLE + 1;

  typedef struct {
    logic [7:0] tt;
    logic [7:0] mm;
    logic [3:0] err;
    logic       pass;
    int         lat;
    logic [2:0] abc;
  } exp_t;

  logic clk;
  logic rst;
  logic [7:0] sop_bad;
  logic [7:0] case_bad;
  logic [2:0] abc;
  logic       maj;
  int tests;
  int fails;
  exp_t q[$];

  punto5_sweep_checker_if bus();

  punto5_sweep_checker #(.SETTLE_CYC(SETTLE), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Logic block under test: majority of A,B,C with per-minterm fault injection.
  assign abc       = {bus.A, bus.B, bus.C};
  assign maj       = (bus.A & bus.B) | (bus.A & bus.C) | (bus.B & bus.C);
  assign bus.Fsimp = maj;
  assign bus.Fpos  = maj;
  assign bus.Fsop  = maj ^ sop_bad[abc];
  assign bus.Fcase = maj ^ case_bad[abc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic maj_model(input int i);
    int ones;
    ones = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
    return ones >= 2;
  endfunction

  function automatic exp_t build_exp(input logic [7:0] sb, input logic [7:0] cb);
    exp_t e;
    logic [7:0] bad;
    bad   = sb | cb;
    e.tt  = '0;
    e.mm  = '0;
    e.err = '0;
    e.abc = 3'b111;
    e.lat = 8 * PER_M;
    for (int i = 0; i < 8; i++) begin
      e.tt[i] = maj_model(i);
      if (bad[i]) begin
        e.mm[i] = 1'b1;
        e.err   = e.err + 4'd1;
`ifdef PUNTO5_STOP_ON_FAIL_EN
        e.abc = 3'(i);
        e.lat = PER_M * (i + 1);
        break;
`endif
      end
    end
    e.pass = (e.err == 4'd0);
    return e;
  endfunction

  // One full sweep: expectation pushed at start, popped and compared when done rises.
  task automatic sweep_check(input string name, input int retrig_at);
    exp_t e;
    int got;
    q.push_back(build_exp(sop_bad, case_bad));
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || abc !== 3'b000 ||
        bus.truth_table !== 8'h00 || bus.mismatch_mask !== 8'h00 || bus.err_count !== 4'd0) begin
      fails++;
      $display("FAIL %s.accept: busy=%b done=%b abc=%b tt=%h mm=%h err=%0d, required busy=1 done=0 all else 0",
               name, bus.busy, bus.done, abc, bus.truth_table, bus.mismatch_mask, bus.err_count);
    end
    got = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin got = k; break; end
      bus.start = (k == retrig_at);
      if (bus.pass !== 1'b0) begin
        tests++; fails++;
        $display("FAIL %s.pass_while_busy: pass=%b at cycle %0d, required 0", name, bus.pass, k);
      end
    end
    bus.start = 1'b0;
    e = q.pop_front();
    tests++;
    if (got !== e.lat) begin
      fails++;
      $display("FAIL %s.latency: done after %0d cycles (0 = timeout), required %0d", name, got, e.lat);
    end
    tests++;
    if (bus.truth_table !== e.tt) begin
      fails++;
      $display("FAIL %s.truth_table: got %h, required %h", name, bus.truth_table, e.tt);
    end
    tests++;
    if (bus.mismatch_mask !== e.mm) begin
      fails++;
      $display("FAIL %s.mismatch_mask: got %h, required %h", name, bus.mismatch_mask, e.mm);
    end
    tests++;
    if (bus.err_count !== e.err) begin
      fails++;
      $display("FAIL %s.err_count: got %0d, required %0d", name, bus.err_count, e.err);
    end
    tests++;
    if (bus.pass !== e.pass || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL %s.pass_busy: pass=%b busy=%b, required pass=%b busy=0", name, bus.pass, bus.busy, e.pass);
    end
    tests++;
    if (abc !== e.abc) begin
      fails++;
      $display("FAIL %s.abc_hold: got %b, required %b", name, abc, e.abc);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0 || abc !== 3'b000 ||
        bus.truth_table !== 8'h00 || bus.mismatch_mask !== 8'h00 || bus.err_count !== 4'd0) begin
      fails++;
      $display("FAIL %s: busy=%b done=%b pass=%b abc=%b tt=%h mm=%h err=%0d, required all 0",
               name, bus.busy, bus.done, bus.pass, abc, bus.truth_table, bus.mismatch_mask, bus.err_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_all_zero("reset_idle");
  endtask

  task automatic test_consistent();
    sop_bad = 8'h00; case_bad = 8'h00;
    sweep_check("consistent", 0);
  endtask

  task automatic test_sop_faults();
    sop_bad = 8'h28; case_bad = 8'h00;
    sweep_check("sop_faults", 0);
    sop_bad = 8'h00;
  endtask

  task automatic test_case_fault();
    sop_bad = 8'h00; case_bad = 8'h04;
    sweep_check("case_fault", 0);
    case_bad = 8'h00;
  endtask

  task automatic test_back_to_back();
    sop_bad = 8'h00; case_bad = 8'h00;
    sweep_check("retrigger", 15);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.done !== 1'b1 || bus.truth_table !== 8'hE8) begin
      fails++;
      $display("FAIL done_hold: done=%b tt=%h, required done=1 tt=e8", bus.done, bus.truth_table);
    end
    sweep_check("restart_from_done", 0);
  endtask

  task automatic test_reset_mid_sweep();
    sop_bad = 8'h00; case_bad = 8'h00;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4 * PER_M + 2) @(posedge clk);
    #1;
    tests++;
    if (abc !== 3'b100 || bus.truth_table !== 8'h08 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_sweep_state: abc=%b tt=%h busy=%b, required abc=100 tt=08 busy=1",
               abc, bus.truth_table, bus.busy);
    end
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("idle_after_reset");
    sweep_check("after_reset", 0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    sop_bad   = 8'h00;
    case_bad  = 8'h00;
    test_reset();
    test_consistent();
    test_sop_faults();
    test_case_fault();
    test_back_to_back();
    test_reset_mid_sweep();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
